div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle RV32M divide unit: DIV, DIVU, REM, REMU.
- Sits alongside the execute stage and is the upstream source of the hold request into the pipeline control block.
- While a divide is in flight it asserts busy_o, which ex drives onto the control block's hold_flag_i to freeze fetch/decode; it then returns one registered result for write-back.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  request a divide; sampled only in IDLE.
- op_i  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU; latched at start.
- dividend_i  input  DATA_WIDTH  rs1 value.
- divisor_i  input  DATA_WIDTH  rs2 value.
- reg_waddr_i  input  5  destination register; latched at start.
- flush_i  input  1  abort in-flight divide (jump from an older instruction).
- busy_o  output  1  hold request to the control block (combinational).
- ready_o  output  1  one-cycle result-valid pulse.
- result_o  output  DATA_WIDTH  quotient or remainder; valid when ready_o=1.
- reg_waddr_o  output  5  latched destination; valid when ready_o=1.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ready_o=0; result_o=0; reg_waddr_o=0.
  - Internal quotient, remainder and counter registers cleared.
  - busy_o=0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1 and flush_i=0:
  - Latch op, reg_waddr and operand signs.
  - Signed ops (DIV, REM) take absolute values of the operands; unsigned ops use raw values.
  - divisor==0: go to DONE, result = all-ones for DIV/DIVU, dividend for REM/REMU.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: go to DONE, result = 0x80000000 for DIV, 0 for REM.
  - Otherwise: go to CALC, counter=0.
- CALC, each cycle:
  - Shift the remainder:dividend pair left by 1.
  - Trial-subtract the divisor from the upper half, DATA_WIDTH+1 bits wide.
  - Non-negative: keep the difference, quotient bit = 1. Negative: restore, quotient bit = 0.
  - Counter increments; after DATA_WIDTH iterations go to DONE.
- DONE (1 cycle):
  - Apply sign fix. Quotient negated if the dividend and divisor signs differ (signed op). Remainder takes the dividend's sign (signed op).
  - ready_o=1, result_o and reg_waddr_o registered.
  - Return to IDLE.
- Latency, start sampled at edge N:
  - Normal divide: ready_o high in cycle N+DATA_WIDTH+1, i.e. 33 cycles at default.
  - Divide-by-zero and overflow: ready_o high in cycle N+1.
- busy_o = (state==IDLE & start_i & ~flush_i) | (state==CALC).
  - Combinational, so the hold reaches the control block in the same cycle as start.
  - busy_o=0 in the DONE cycle, so the pipeline resumes while the result is written.
- ready_o is a single-cycle pulse. result_o holds its last value otherwise but is don't-care when ready_o=0.
- start_i while in CALC or DONE: ignored, no re-latch.
- flush_i=1 in CALC: return to IDLE next edge; no ready_o pulse; busy_o drops next cycle.
- flush_i in DONE: ignored; the result is still delivered. Ex gates the write if needed.
- start_i and flush_i both high in IDLE: flush wins, no operation starts.
- Arithmetic: all magnitudes are unsigned DATA_WIDTH. Negation is two's complement. Intermediate subtract is DATA_WIDTH+1 bits to catch the borrow.

Test Plan:
- DIVU 100/7, waddr=5 → busy_o high 32 cycles after start; ready_o pulse at N+33 with result_o=14, reg_waddr_o=5.
- DIV -100/7 (0xFFFFFF9C / 7) → result_o=0xFFFFFFF2 (-14).
- REM -100/7 → result_o=0xFFFFFFFE (-2).
- REMU 0xFFFFFFFF/16 → result_o=15.
- Boundary operands:
  - DIVU x/0 with x=1234 → ready_o at N+1, result_o=0xFFFFFFFF.
  - REM 1234/0 → result_o=1234.
  - DIV 0x80000000/0xFFFFFFFF → result_o=0x80000000 at N+1.
  - REM 0x80000000/0xFFFFFFFF → result_o=0.
- Abort and reset during a divide:
  - DIVU 1000/3 with flush_i pulsed at CALC cycle 10 → no ready_o; busy_o low the next cycle.
  - A new DIVU 9/3 started afterwards returns 3.
  - rst asserted mid-CALC → all outputs 0 immediately, state IDLE; start_i held high during the same window produces no result after rst releases until start is re-sampled.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divide unit.
interface div_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_i;
   logic [1:0]            op_i;
   logic [DATA_WIDTH-1:0] dividend_i;
   logic [DATA_WIDTH-1:0] divisor_i;
   logic [4:0]            reg_waddr_i;
   logic                  flush_i;
   logic                  busy_o;
   logic                  ready_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic [4:0]            reg_waddr_o;
   modport master (
      output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
      input  busy_o, ready_o, result_o, reg_waddr_o
   );
   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
      output busy_o, ready_o, result_o, reg_waddr_o
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// busy_o holds the pipeline while dividing; one registered result pulse on ready_o.
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DW);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
   state_e          state_q, state_d;
   logic [DW-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, result_q, result_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic [4:0]      waddr_q, waddr_d, waddr_o_q, waddr_o_d;
   logic            neg_q, neg_d, sdiff_q, sdiff_d, spec_q, spec_d, ready_q, ready_d;
   logic            signed_op, a_neg, b_neg, div0, ovf, accept, last, borrow;
   logic [DW-1:0]   a_abs, b_abs, q_fix, r_fix, fixed;
   logic [DW:0]     shifted, diff;
   always_comb begin
      signed_op = ~bus.op_i[0];
      a_neg     = signed_op & bus.dividend_i[DW-1];
      b_neg     = signed_op & bus.divisor_i[DW-1];
      a_abs     = a_neg ? -bus.dividend_i : bus.dividend_i;
      b_abs     = b_neg ? -bus.divisor_i : bus.divisor_i;
      div0      = bus.divisor_i == '0;
      ovf       = signed_op & (bus.dividend_i == {1'b1, {(DW-1){1'b0}}}) & (&bus.divisor_i);
      accept    = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
      last      = cnt_q == CW'(DW-1);
      // upper half widened by one bit so the borrow of the trial subtract is visible
      shifted   = {rem_q, quo_q[DW-1]};
      diff      = shifted - {1'b0, dvsr_q};
      borrow    = diff[DW];
      q_fix     = sdiff_q ? -quo_q : quo_q;
      r_fix     = neg_q ? -rem_q : rem_q;
      fixed     = spec_q ? quo_q : (op_q[1] ? r_fix : q_fix);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = accept ? ((div0 | ovf) ? DONE : CALC) : IDLE;
         CALC:    state_d = bus.flush_i ? IDLE : (last ? DONE : CALC);
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.busy_o      = ~rst & (accept | (state_q == CALC));
      bus.ready_o     = ready_q;
      bus.result_o    = result_q;
      bus.reg_waddr_o = waddr_o_q;
   end
   always_comb begin
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      waddr_d   = waddr_q;
      neg_d     = neg_q;
      sdiff_d   = sdiff_q;
      spec_d    = spec_q;
      ready_d   = state_q == DONE;
      result_d  = (state_q == DONE) ? fixed : result_q;
      waddr_o_d = (state_q == DONE) ? waddr_q : waddr_o_q;
      if (accept) begin
         op_d    = bus.op_i;
         waddr_d = bus.reg_waddr_i;
         neg_d   = a_neg;
         sdiff_d = a_neg ^ b_neg;
         dvsr_d  = b_abs;
         rem_d   = '0;
         cnt_d   = '0;
         spec_d  = div0 | ovf;
         // special cases park their final answer in the quotient register
         quo_d   = div0 ? (bus.op_i[1] ? bus.dividend_i : '1) :
                   ovf  ? (bus.op_i[1] ? '0 : bus.dividend_i) : a_abs;
      end else if (state_q == CALC) begin
         rem_d = borrow ? shifted[DW-1:0] : diff[DW-1:0];
         quo_d = {quo_q[DW-2:0], ~borrow};
         cnt_d = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         waddr_q   <= '0;
         neg_q     <= 1'b0;
         sdiff_q   <= 1'b0;
         spec_q    <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
         waddr_o_q <= '0;
      end else begin
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         waddr_q   <= waddr_d;
         neg_q     <= neg_d;
         sdiff_q   <= sdiff_d;
         spec_q    <= spec_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
         waddr_o_q <= waddr_o_d;
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with a scoreboard queue drained by a ready_o monitor.
module tb_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   div_unit_if #(.DATA_WIDTH(32)) bus ();
   div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [31:0] res;
      logic [4:0]  wa;
      int          due;
   } exp_t;
   exp_t sb[$];
   exp_t e_mon;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   readies = 0;
   int   busy_base = 0;
   int   r0 = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (bus.ready_o === 1'b1) begin
         readies++;
         if (sb.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
         else begin
            e_mon = sb.pop_front();
            chk("result", bus.result_o, e_mon.res);
            chk("waddr", {27'd0, bus.reg_waddr_o}, {27'd0, e_mon.wa});
            chk("latency", cyc, e_mon.due);
         end
      end
   end
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input bit push, input logic [31:0] exp, input int lat);
      exp_t e;
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i = op;
      bus.dividend_i = a;
      bus.divisor_i = b;
      bus.reg_waddr_i = wa;
      #1 chk("busy_at_start", {31'd0, bus.busy_o}, 32'd1);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      busy_base = busy_cnt;
      if (push) begin
         e.res = exp;
         e.wa  = wa;
         e.due = cyc + lat;
         sb.push_back(e);
      end
   endtask
   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         #1 n++;
      end
      chk("timeout_pending", sb.size(), 32'd0);
      sb.delete();
   endtask
   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] wa, input logic [31:0] exp, input int lat);
      issue(op, a, b, wa, 1'b1, exp, lat);
      wait_done();
      chk("busy_cycles", busy_cnt - busy_base, (lat == 1) ? 32'd0 : 32'd32);
   endtask
   initial begin
      bus.start_i = 1'b1;
      bus.op_i = 2'd1;
      bus.dividend_i = 32'd100;
      bus.divisor_i = 32'd7;
      bus.reg_waddr_i = 5'd1;
      bus.flush_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
      chk("rst_result", bus.result_o, 32'd0);
      chk("rst_waddr", {27'd0, bus.reg_waddr_o}, 32'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run(2'd1, 32'd100, 32'd7, 5'd5, 32'd14, 33);
      run(2'd0, 32'hFFFFFF9C, 32'd7, 5'd6, 32'hFFFFFFF2, 33);
      run(2'd2, 32'hFFFFFF9C, 32'd7, 5'd7, 32'hFFFFFFFE, 33);
      run(2'd3, 32'hFFFFFFFF, 32'd16, 5'd8, 32'd15, 33);
      run(2'd0, 32'd100, 32'hFFFFFFF9, 5'd9, 32'hFFFFFFF2, 33);
      run(2'd2, 32'd100, 32'hFFFFFFF9, 5'd10, 32'd2, 33);
      run(2'd1, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0, 33);
      run(2'd3, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 33);
      run(2'd1, 32'hFFFFFFFF, 32'd1, 5'd13, 32'hFFFFFFFF, 33);
      run(2'd0, 32'd7, 32'd100, 5'd14, 32'd0, 33);
      run(2'd1, 32'd1234, 32'd0, 5'd15, 32'hFFFFFFFF, 1);
      run(2'd2, 32'd1234, 32'd0, 5'd16, 32'd1234, 1);
      run(2'd0, 32'hFFFFFFF9, 32'd0, 5'd17, 32'hFFFFFFFF, 1);
      run(2'd2, 32'hFFFFFFF9, 32'd0, 5'd18, 32'hFFFFFFF9, 1);
      run(2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1);
      run(2'd2, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0, 1);
      // a second start while calculating must not re-latch anything
      issue(2'd1, 32'd200, 32'd9, 5'd3, 1'b1, 32'd22, 33);
      repeat (5) @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i = 2'd3;
      bus.dividend_i = 32'd50;
      bus.divisor_i = 32'd4;
      bus.reg_waddr_i = 5'd30;
      repeat (2) @(negedge clk);
      bus.start_i = 1'b0;
      wait_done();
      // flush mid-calculation
      issue(2'd1, 32'd1000, 32'd3, 5'd21, 1'b0, 32'd0, 0);
      r0 = readies;
      repeat (10) @(negedge clk);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1 bus.flush_i = 1'b0;
      @(negedge clk);
      chk("busy_after_flush", {31'd0, bus.busy_o}, 32'd0);
      repeat (40) @(negedge clk);
      chk("no_ready_after_flush", readies, r0);
      run(2'd1, 32'd9, 32'd3, 5'd22, 32'd3, 33);
      // start and flush together in IDLE
      r0 = readies;
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      bus.op_i = 2'd1;
      bus.dividend_i = 32'd9;
      bus.divisor_i = 32'd3;
      #1 chk("busy_start_flush", {31'd0, bus.busy_o}, 32'd0);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_ready_start_flush", readies, r0);
      // asynchronous reset mid-calculation with start held
      issue(2'd1, 32'd1000, 32'd3, 5'd23, 1'b0, 32'd0, 0);
      repeat (5) @(negedge clk);
      bus.start_i = 1'b1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("midrst_ready", {31'd0, bus.ready_o}, 32'd0);
      chk("midrst_result", bus.result_o, 32'd0);
      chk("midrst_waddr", {27'd0, bus.reg_waddr_o}, 32'd0);
      repeat (3) @(negedge clk);
      bus.start_i = 1'b0;
      rst = 1'b0;
      r0 = readies;
      repeat (40) @(negedge clk);
      chk("no_ready_after_rst", readies, r0);
      run(2'd3, 32'd100, 32'd7, 5'd24, 32'd2, 33);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
